apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, minimum 2).
REQ-002 SHALL have port PCLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port PRESETn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  transfer address.
REQ-008 SHALL have port cmd_wdata  input  32  write data; ignored for reads.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion strobe; no backpressure.
REQ-010 SHALL have port rsp_write  output  1  type of the completed transfer.
REQ-011 SHALL have port rsp_rdata  output  32  read data of the completed read; 0 for writes.
REQ-012 SHALL have port busy  output  1  transfer in flight or FIFO non-empty.
REQ-013 SHALL have APB ports PADDR out 32, PSELx out 1, PENABLE out 1, PWRITE out 1, PWDATA out 32, PRDATA in 32; no PREADY/PSLVERR (fixed two-cycle APB transfers).

Function
REQ-014 SHALL accept a command on a rising edge with cmd_valid && cmd_ready; cmd_ready = !fifo_full, registered-free (combinational from FIFO count).
REQ-015 SHALL run FSM IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-016 IDLE: PSELx=0, PENABLE=0; on an edge with FIFO non-empty, SHALL pop one entry, load PADDR/PWRITE/PWDATA, go to SETUP.
REQ-017 SETUP: PSELx=1, PENABLE=0; SHALL go to ACCESS on the next edge unconditionally.
REQ-018 ACCESS: PSELx=1, PENABLE=1; on the next edge SHALL sample PRDATA (reads), drive rsp_valid=1 for exactly one cycle, then go to SETUP with the next entry if FIFO non-empty (PSELx stays 1), else IDLE.
REQ-019 Latency: accept edge E0 -> SETUP after E1 -> ACCESS after E2 -> rsp_valid high in the cycle after E3.
REQ-020 Back-to-back throughput SHALL be one transfer per 2 PCLK cycles.
REQ-021 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through ACCESS and SHALL hold last values in IDLE.
REQ-022 FIFO SHALL allow simultaneous push and pop in one edge, including when full (pop frees slot; cmd_ready still low that cycle) and when holding one entry.
REQ-023 Commands SHALL complete in acceptance order; none dropped or duplicated outside reset.
REQ-024 busy SHALL be 1 whenever state != IDLE or FIFO non-empty.

Reset
REQ-025 On an edge with PRESETn=0: state=IDLE, FIFO emptied, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0.
REQ-026 cmd_ready SHALL be 0 while PRESETn=0.
REQ-027 Reset mid-transfer SHALL abort it with no rsp_valid; queued commands are discarded.

Structure
REQ-028 Package apb_pkg SHALL hold the FSM state enum, APB_ADDR_W=32, APB_DATA_W=32, and the command entry struct (write, addr, wdata).
REQ-029 Sub-module apb_cmd_fifo SHALL implement the synchronous FIFO (push, pop, full, empty, count), reset by PRESETn.

Verification
REQ-030 Single write addr 0x10 data 0xDEADBEEF -> PSELx=1/PENABLE=0 one cycle, then PENABLE=1 one cycle, PWRITE=1, rsp_valid one cycle after E3, rsp_rdata=0.
REQ-031 Single read addr 0x20, slave model drives PRDATA=0x12345678 -> rsp_write=0, rsp_rdata=0x12345678.
REQ-032 Four back-to-back reads pushed in consecutive cycles -> PSELx continuously 1, PENABLE toggles 0/1, four rsp_valid pulses 2 cycles apart, data in order.
REQ-033 Push 6 commands with FIFO_DEPTH=4 while master busy -> cmd_ready drops at full, rises after the first pop; all 6 complete in order.
REQ-034 PRESETn=0 during ACCESS of a write with 2 queued -> next cycle PSELx=0, PENABLE=0, no rsp_valid, busy=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master types, widths and command entry layout
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_e;
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;
endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous command FIFO (push/pop same edge, full/empty/count), reset by PRESETn
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   push,
  input  logic                   pop,
  input  apb_cmd_t               wr_data,
  output apb_cmd_t               rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  apb_cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/apb_master.sv
// apb_master: queued command interface driving fixed two-cycle APB transfers with one-cycle completion strobe
module apb_master
  import apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  busy,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA
);
  apb_state_e state_q, state_d;
  apb_cmd_t head;
  logic full, empty, pop;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic pwrite_q, pwrite_d, rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (cmd_valid && cmd_ready),
    .pop     (pop),
    .wr_data ('{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  assign cmd_ready = PRESETn && !full;
  assign busy      = state_q != ST_IDLE || count != '0;
  assign PSELx     = state_q != ST_IDLE;
  assign PENABLE   = state_q == ST_ACCESS;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  always_comb begin
    pop         = state_q != ST_SETUP && !empty;
    state_d     = state_q == ST_SETUP ? ST_ACCESS : empty ? ST_IDLE : ST_SETUP;
    paddr_d     = pop ? head.addr : paddr_q;
    pwrite_d    = pop ? head.write : pwrite_q;
    pwdata_d    = pop ? head.wdata : pwdata_q;
    rsp_valid_d = state_q == ST_ACCESS;
    rsp_write_d = rsp_valid_d ? pwrite_q : rsp_write_q;
    rsp_rdata_d = rsp_valid_d ? (pwrite_q ? '0 : PRDATA) : rsp_rdata_q;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule
